// File: rtl/output_display_if.sv
// ---------------------------------------------------------------------------
// output_display_if
// Bundles the signals between the CPU output stage and the display driver.
//   bus         : data bus byte (A register during OUT)          master -> slave
//   out_en      : capture strobe from the control unit           master -> slave
//   signed_mode : 1 = treat the captured byte as two's complement master -> slave
//   seg         : segments {g,f,e,d,c,b,a}, active-low            slave -> master
//   an          : digit anodes, active-low (0 units .. 3 sign)    slave -> master
//   dp          : decimal point, active-low (always off)          slave -> master
//   value       : last captured byte, raw                         slave -> master
//   busy        : conversion in progress                          slave -> master
// ---------------------------------------------------------------------------
interface output_display_if;
    logic [7:0] bus;
    logic       out_en;
    logic       signed_mode;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic [7:0] value;
    logic       busy;

    modport master (
        output bus, out_en, signed_mode,
        input  seg, an, dp, value, busy
    );

    modport slave (
        input  bus, out_en, signed_mode,
        output seg, an, dp, value, busy
    );
endinterface

// File: rtl/output_display.sv
// ---------------------------------------------------------------------------
// output_display
// Output-stage display driver. Captures the bus byte on out_en, converts it
// to sign + three BCD digits with a sequential double-dabble (8 cycles), and
// drives a 4-digit multiplexed common-anode 7-segment display.
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   io  : output_display_if.slave (bus, out_en, signed_mode in;
//         seg, an, dp, value, busy out)
// Parameter SCAN_DIV (>=2): clock cycles each digit stays lit.
// ---------------------------------------------------------------------------
module output_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    output_display_if.slave  io
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic {S_IDLE, S_CONVERT} state_t;

    // Conversion state
    state_t      r_state;
    logic        r_busy;
    logic [7:0]  r_value;
    logic        r_neg;
    logic [19:0] r_shift;
    logic [2:0]  r_iter;

    // Display registers: only written on conversion completion or reset
    logic        r_neg_d;
    logic [3:0]  r_hund;
    logic [3:0]  r_tens;
    logic [3:0]  r_units;

    // Scan state and registered display outputs
    logic [CNT_W-1:0] r_scan_cnt;
    logic [1:0]       r_digit_idx;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;

    logic        w_neg;
    logic [7:0]  w_mag;
    logic [19:0] w_adj;
    logic [19:0] w_next;
    logic [6:0]  w_digit_seg;

    function automatic logic [3:0] f_dabble(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Magnitude of the incoming byte; 0x80 in signed mode yields 128 because
    // the negation wraps to 0x80, which is read back as unsigned.
    assign w_neg = io.signed_mode & io.bus[7];
    assign w_mag = w_neg ? (8'd0 - io.bus) : io.bus;

    // One double-dabble iteration: add-3 on BCD nibbles >= 5, then shift left
    assign w_adj  = {f_dabble(r_shift[19:16]), f_dabble(r_shift[15:12]),
                     f_dabble(r_shift[11:8]), r_shift[7:0]};
    assign w_next = {w_adj[18:0], 1'b0};

    // Capture / conversion FSM. A capture always wins over an iteration so a
    // recapture restarts the conversion and the old partial result is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_value <= 8'd0;
            r_neg   <= 1'b0;
            r_shift <= 20'd0;
            r_iter  <= 3'd0;
            r_neg_d <= 1'b0;
            r_hund  <= 4'd0;
            r_tens  <= 4'd0;
            r_units <= 4'd0;
        end else if (io.out_en) begin
            r_value <= io.bus;
            r_neg   <= w_neg;
            r_shift <= {12'd0, w_mag};
            r_iter  <= 3'd0;
            r_state <= S_CONVERT;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                S_CONVERT: begin
                    r_shift <= w_next;
                    r_iter  <= r_iter + 3'd1;
                    if (r_iter == 3'd7) begin
                        r_neg_d <= r_neg;
                        r_hund  <= w_next[19:16];
                        r_tens  <= w_next[15:12];
                        r_units <= w_next[11:8];
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pattern for the digit currently selected, with leading-zero blanking
    always_comb begin
        w_digit_seg = SEG_BLANK;
        case (r_digit_idx)
            2'd0: w_digit_seg = f_seg(r_units);
            2'd1: if ((r_hund != 4'd0) || (r_tens != 4'd0)) w_digit_seg = f_seg(r_tens);
            2'd2: if (r_hund != 4'd0) w_digit_seg = f_seg(r_hund);
            default: if (r_neg_d) w_digit_seg = SEG_MINUS;
        endcase
    end

    // Free-running scan; seg/an are registered so they change together
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= 2'd0;
            r_an        <= 4'b1110;
            r_seg       <= 7'b1000000;
        end else begin
            if (r_scan_cnt == CNT_LAST) begin
                r_scan_cnt  <= '0;
                r_digit_idx <= r_digit_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_an  <= ~(4'b0001 << r_digit_idx);
            r_seg <= w_digit_seg;
        end
    end

    assign io.seg   = r_seg;
    assign io.an    = r_an;
    assign io.dp    = 1'b1;
    assign io.value = r_value;
    assign io.busy  = r_busy;

endmodule

// File: tb/tb_output_display.sv
module tb_output_display;

    localparam int SCAN_DIV = 4;

    typedef struct {
        bit neg;
        int mag;
    } disp_t;

    logic clk = 1'b0;
    logic rst;

    output_display_if io();

    output_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state (updated at each rising edge by tick)
    disp_t      sb[$];
    int         m_cd     = 0;
    bit         m_busy   = 1'b0;
    logic [7:0] m_value  = 8'd0;
    int         m_cnt    = 0;
    int         m_idx    = 0;
    logic [3:0] exp_an   = 4'b1110;
    bit         rst_edge = 1'b0;
    bit         started  = 1'b0;

    // Monitor state
    disp_t mon_disp = '{neg: 1'b0, mag: 0};
    bit    prev_busy = 1'b0;

    logic [6:0] digpat [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    function automatic logic [6:0] exp_seg(input disp_t d, input int p);
        logic [6:0] s;
        s = 7'b1111111;
        case (p)
            0: s = digpat[d.mag % 10];
            1: if (d.mag >= 10)  s = digpat[(d.mag / 10) % 10];
            2: if (d.mag >= 100) s = digpat[d.mag / 100];
            default: if (d.neg) s = 7'b0111111;
        endcase
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; the model consumes the inputs the DUT samples there
    task automatic tick();
        disp_t e;
        int    v;
        @(posedge clk);
        if (rst) exp_an = 4'b1110;
        else     exp_an = ~(4'b0001 << m_idx);
        if (rst) begin
            m_cnt = 0;
            m_idx = 0;
        end else if (m_cnt == SCAN_DIV - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 4;
        end else begin
            m_cnt++;
        end
        if (rst) begin
            rst_edge = 1'b1;
            m_value  = 8'd0;
            m_cd     = 0;
            sb.delete();
        end else begin
            rst_edge = 1'b0;
            if (io.out_en) begin
                if (m_cd > 0) void'(sb.pop_back());
                v     = int'(io.bus);
                e.neg = io.signed_mode && (v >= 128);
                e.mag = e.neg ? (256 - v) : v;
                sb.push_back(e);
                m_value = io.bus;
                m_cd    = 8;
            end else if (m_cd > 0) begin
                m_cd--;
            end
        end
        m_busy  = (m_cd > 0);
        started = 1'b1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic capture(input logic [7:0] b, input logic sm);
        io.bus         = b;
        io.signed_mode = sm;
        io.out_en      = 1'b1;
        tick();
        io.out_en      = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    // Monitor: compares outputs at the falling edge and retires expected
    // display results whenever the DUT drops busy after a conversion.
    initial begin
        int p;
        forever begin
            @(negedge clk);
            if (started) begin
                if (rst_edge) mon_disp = '{neg: 1'b0, mag: 0};
                p = 0;
                for (int i = 0; i < 4; i++) if (!exp_an[i]) p = i;
                chk("an",    32'(io.an),    32'(exp_an));
                chk("seg",   32'(io.seg),   32'(exp_seg(mon_disp, p)));
                chk("busy",  32'(io.busy),  32'(m_busy));
                chk("value", 32'(io.value), 32'(m_value));
                chk("dp",    32'(io.dp),    32'd1);
                if (prev_busy && !io.busy && !rst_edge) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL completion: got unexpected busy fall, expected none at %0t", $time);
                    end else begin
                        mon_disp = sb.pop_front();
                    end
                end
                prev_busy = io.busy;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        io.bus         = 8'd0;
        io.out_en      = 1'b0;
        io.signed_mode = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(20);

        capture(8'hFF, 1'b0); idle(24);
        capture(8'h80, 1'b1); idle(24);
        capture(8'hFE, 1'b1); idle(24);
        capture(8'h07, 1'b0); idle(24);
        capture(8'h64, 1'b0); idle(24);

        do_reset(2); idle(5);
        capture(8'h0C, 1'b0); idle(3);
        capture(8'h63, 1'b0); idle(24);

        capture(8'hC8, 1'b0); idle(2);
        do_reset(1); idle(24);

        // out_en held three cycles with changing data
        io.out_en = 1'b1;
        io.signed_mode = 1'b1;
        io.bus = 8'h11; tick();
        io.bus = 8'h9C; tick();
        io.bus = 8'hF6; tick();
        io.out_en = 1'b0;
        idle(24);

        // reset and capture in the same cycle: nothing is captured
        io.bus = 8'hAA; io.out_en = 1'b1; rst = 1'b1; tick();
        io.out_en = 1'b0; rst = 1'b0; idle(20);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset(1);
            end else begin
                capture(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                idle($urandom_range(0, 14));
            end
        end
        idle(30);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
